digit_sum_receiver: RTL and testbench

DIGIT_SUM_RECEIVER -- requirements
Module: digit_sum_receiver

---
 rtl/ncl_pkg.sv | 17 +
 rtl/ncl_rail_sync.sv | 32 +++
 rtl/digit_sum_receiver.sv | 131 +++++++++++++
 tb/tb_digit_sum_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared definitions for the NCL dual-rail receive path: per-digit rail codes
// and the receiver handshake state encoding.
package ncl_pkg;

    // Two-bit digit code as {rail1, rail0}.
    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_DATA0   = 2'b01;
    localparam logic [1:0] DR_DATA1   = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        WAIT_NULL = 2'd0,
        WAIT_DATA = 2'd1,
        CAPTURE   = 2'd2
    } rx_state_e;

endpackage : ncl_pkg

// File: rtl/ncl_rail_sync.sv
// Multi-stage flop synchroniser applied bitwise to a bus of independent
// asynchronous rails; each bit is synchronised on its own.
module ncl_rail_sync #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             init,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: the synchroniser chain is cleared on reset so no stale rail value
    // from before reset can be mistaken for a fresh wavefront afterwards.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule : ncl_rail_sync

// File: rtl/digit_sum_receiver.sv
// Clocked receiver for a dual-rail NCL sum wavefront: synchronises the rails,
// runs the NULL/DATA completion handshake and checks the captured sequence.
module digit_sum_receiver
    import ncl_pkg::*;
#(
    parameter int NDIGITS     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   init,
    input  logic [2*NDIGITS-1:0]   displaysum,
    output logic                   ko,
    output logic [NDIGITS-1:0]     dout,
    output logic                   dout_valid,
    output logic                   seq_err,
    output logic                   illegal_err,
    output logic [15:0]            word_count
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

    logic [2*NDIGITS-1:0] rails_sync;
    logic [NDIGITS-1:0]   is_null;
    logic [NDIGITS-1:0]   is_data;
    logic [NDIGITS-1:0]   is_ill;
    logic [NDIGITS-1:0]   rail1;
    logic [FILL_W-1:0]    fill_q;
    logic                 primed;
    logic                 all_null;
    logic                 all_data;
    logic                 any_ill;
    logic                 capture_go;
    logic                 ref_valid;
    rx_state_e            state_q;
    rx_state_e            state_d;

    ncl_rail_sync #(
        .WIDTH  (2*NDIGITS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .init (init),
        .d    (displaysum),
        .q    (rails_sync)
    );

    // Reset-cleared sync flops hold zeros, not sampled pins; completeness is
    // only trusted once the chain has been refilled with real samples.
    always_ff @(posedge clk) begin
        if (init) begin
            fill_q <= '0;
        end else if (fill_q != FILL_MAX) begin
            fill_q <= fill_q + 1'b1;
        end
    end

    assign primed = (fill_q == FILL_MAX);

    // NOTE: every variable of a combinational block gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        is_null = '0;
        is_data = '0;
        is_ill  = '0;
        rail1   = '0;
        for (int k = 0; k < NDIGITS; k++) begin
            case (rails_sync[2*k +: 2])
                DR_NULL:            is_null[k] = 1'b1;
                DR_DATA0, DR_DATA1: is_data[k] = 1'b1;
                default:            is_ill[k]  = 1'b1;
            endcase
            rail1[k] = rails_sync[2*k+1];
        end
    end

    assign all_null = primed & (&is_null);
    assign all_data = primed & (&is_data);
    assign any_ill  = primed & (|is_ill);

    // An illegal digit freezes the handshake until reset.
    always_comb begin
        state_d    = state_q;
        capture_go = 1'b0;
        if (!(illegal_err || any_ill)) begin
            case (state_q)
                WAIT_NULL: if (all_null) state_d = WAIT_DATA;
                WAIT_DATA: begin
                    if (all_data) begin
                        state_d    = CAPTURE;
                        capture_go = 1'b1;
                    end
                end
                CAPTURE:   state_d = WAIT_NULL;
                default:   state_d = WAIT_NULL;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop here
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q     <= WAIT_NULL;
            ko          <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            seq_err     <= 1'b0;
            illegal_err <= 1'b0;
            word_count  <= '0;
            ref_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ko         <= (state_d == WAIT_DATA);
            dout_valid <= capture_go;
            seq_err    <= 1'b0;
            if (any_ill) begin
                illegal_err <= 1'b1;
            end
            if (capture_go) begin
                dout      <= rail1;
                seq_err   <= ref_valid && (rail1 != dout + 1'b1);
                ref_valid <= 1'b1;
                if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end
        end
    end

endmodule : digit_sum_receiver

// File: tb/tb_digit_sum_receiver.sv
// Randomised scoreboard bench for digit_sum_receiver: a driver performs the
// four-phase dual-rail handshake, a monitor checks each capture against a model.
module tb_digit_sum_receiver;

    localparam int N = 32;
    localparam int S = 2;

    typedef struct {
        logic [N-1:0] val;
        logic         seq;
        logic [15:0]  cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           init;
    logic [2*N-1:0] displaysum;
    logic           ko;
    logic [N-1:0]   dout;
    logic           dout_valid;
    logic           seq_err;
    logic           illegal_err;
    logic [15:0]    word_count;

    int checks   = 0;
    int failures = 0;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [N-1:0] m_prev;
    logic         m_ref_valid;
    logic [15:0]  m_count;

    digit_sum_receiver #(.NDIGITS(N), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .init        (init),
        .displaysum  (displaysum),
        .ko          (ko),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .seq_err     (seq_err),
        .illegal_err (illegal_err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sequence rule and saturating count, straight from the rules.
    task automatic push_expected(input logic [N-1:0] v);
        exp_t         e;
        logic [N-1:0] nxt;
        nxt   = m_prev + 1'b1;
        e.val = v;
        e.seq = m_ref_valid && (v != nxt);
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        e.cnt       = m_count;
        m_prev      = v;
        m_ref_valid = 1'b1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dout_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("dout", dout, mon_e.val);
                check("seq_err", seq_err, mon_e.seq);
                check("word_count", word_count, mon_e.cnt);
                check("ko_low_at_capture", ko, 0);
            end
        end else if (seq_err) begin
            check("seq_err_without_valid", seq_err, 0);
        end
    end

    task automatic set_digit(input int k, input logic [1:0] code);
        displaysum[2*k +: 2] = code;
    endtask

    task automatic wait_ko(input logic lvl, input int budget);
        int n = 0;
        while (ko !== lvl && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (ko !== lvl) check("ko_timeout", ko, lvl);
    endtask

    // Drives a DATA (data=1) or NULL (data=0) wavefront in random skewed order.
    task automatic drive_wave(input logic [N-1:0] val, input bit data,
                              input bit in_order, input int max_step);
        int order[N];
        int idx;
        int n;
        int j;
        int t;
        for (int i = 0; i < N; i++) order[i] = i;
        if (!in_order) begin
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        idx = 0;
        while (idx < N) begin
            @(posedge clk); #1;
            check(data ? "ko_hold_data" : "ko_hold_null", ko, data);
            n = $urandom_range(max_step, 1);
            for (int m = 0; m < n && idx < N; m++) begin
                if (data) set_digit(order[idx], val[order[idx]] ? 2'b10 : 2'b01);
                else      set_digit(order[idx], 2'b00);
                idx++;
            end
        end
        if (data) push_expected(val);
    endtask

    task automatic wavefront(input logic [N-1:0] v);
        wait_ko(1'b1, 50);
        drive_wave(v, 1'b1, 1'b0, 4);
        wait_ko(1'b0, 50);
        drive_wave('0, 1'b0, 1'b0, 4);
    endtask

    task automatic hold_reset(input int cycles);
        init = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        m_ref_valid = 1'b0;
        m_count     = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ko"}, ko, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_seq_err"}, seq_err, 0);
        check({tag, "_illegal_err"}, illegal_err, 0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    initial begin
        logic [N-1:0] v;
        init        = 1'b1;
        displaysum  = '0;
        m_prev      = '0;
        m_ref_valid = 1'b0;
        m_count     = '0;

        // Scenario 1: release with all-NULL input, ko latency.
        hold_reset(3);
        check_all_zero("reset");
        init = 1'b0;
        for (int i = 1; i <= S + 1; i++) begin
            @(posedge clk); #1;
            check("s1_ko_latency", ko, (i == S + 1));
        end
        check("s1_dout", dout, 0);
        check("s1_word_count", word_count, 0);

        // Scenario 2: one digit per cycle, in order.
        drive_wave(N'(5), 1'b1, 1'b1, 1);
        for (int i = 1; i <= S + 1; i++) begin
            @(posedge clk); #1;
            check("s2_valid_latency", dout_valid, (i == S + 1));
        end
        check("s2_ko_fell", ko, 0);
        drive_wave('0, 1'b0, 1'b0, 4);

        // Scenario 3: wrap-around is legal, a jump is not.
        hold_reset(2);
        init = 1'b0;
        wavefront(32'hFFFF_FFFE);
        wavefront(32'hFFFF_FFFF);
        wavefront(32'h0000_0000);
        wait_ko(1'b1, 50);
        drive_wave(32'h0000_0002, 1'b1, 1'b0, 4);
        wait_ko(1'b0, 50);
        check("s3_word_count", word_count, 4);
        drive_wave('0, 1'b0, 1'b0, 4);

        // Randomised traffic: mix of in-sequence and arbitrary values.
        for (int w = 0; w < 25; w++) begin
            v = ($urandom_range(1, 0) == 1) ? m_prev + 1'b1 : N'($urandom);
            wavefront(v);
        end

        // Scenario 6: one straggling digit holds ko low.
        wait_ko(1'b1, 50);
        v = N'($urandom);
        v[N-1] = 1'b1;
        drive_wave(v, 1'b1, 1'b0, 4);
        wait_ko(1'b0, 50);
        for (int k = 0; k < N - 1; k++) begin
            @(posedge clk); #1;
            check("s6_ko_low_skew", ko, 0);
            set_digit(k, 2'b00);
        end
        repeat (10) begin
            @(posedge clk); #1;
            check("s6_ko_low_straggler", ko, 0);
        end
        set_digit(N - 1, 2'b00);
        for (int i = 1; i <= S + 1; i++) begin
            @(posedge clk); #1;
            check("s6_ko_latency", ko, (i == S + 1));
        end

        // Scenario 4: illegal digit during WAIT_DATA is sticky and blocks capture.
        set_digit(7, 2'b11);
        repeat (S + 2) @(posedge clk);
        #1;
        check("s4_illegal_set", illegal_err, 1);
        for (int k = 0; k < N; k++) set_digit(k, 2'b01);
        repeat (10) begin
            @(posedge clk); #1;
            check("s4_illegal_sticky", illegal_err, 1);
            check("s4_ko_held", ko, 1);
        end
        displaysum = '0;
        repeat (6) begin
            @(posedge clk); #1;
            check("s4_ko_held_null", ko, 1);
        end
        hold_reset(2);
        check_all_zero("s4_reset");
        init = 1'b0;

        // Scenario 5: reset mid-wavefront discards the partial data.
        wait_ko(1'b1, 50);
        for (int k = 0; k < 20; k++) set_digit(k, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        hold_reset(2);
        check_all_zero("s5_reset");
        init = 1'b0;
        for (int k = 20; k < N; k++) set_digit(k, 2'b01);
        repeat (12) begin
            @(posedge clk); #1;
            check("s5_no_ko_without_null", ko, 0);
        end
        drive_wave('0, 1'b0, 1'b0, 4);
        wavefront(N'($urandom));
        wavefront(m_prev + 1'b1);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_digit_sum_receiver
